// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for alu_req_sequencer and alu_core.
package alu_seq_pkg;

  localparam logic [1:0] OP_INV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DBL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-op ALU (invert, add, subtract, double); all results wrap mod 2^WIDTH.
// With ALU_SEQ_FLAGS_EN defined it is built one bit wider and exports that bit as carry/borrow.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             c
`endif
);

`ifdef ALU_SEQ_FLAGS_EN
  // The extra top bit is the carry for add, the borrow for subtract and the shifted-out MSB for double.
  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    case (s)
      OP_INV:  ext = {1'b0, ~a};
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_DBL:  ext = {a, 1'b0};
      default: ext = '0;
    endcase
  end

  assign y = ext[WIDTH-1:0];
  assign c = ext[WIDTH];
`else
  always_comb begin
    y = '0;
    case (s)
      OP_INV:  y = ~a;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_DBL:  y = a << 1;
      default: y = '0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_req_sequencer.sv
// Round-robin sequencer sharing one alu_core between N_REQ valid/ready requesters.
// Optional carry/borrow output res_C is enabled by defining ALU_SEQ_FLAGS_EN.
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_A,
  input  logic [N_REQ*WIDTH-1:0] req_B,
  input  logic [N_REQ*2-1:0]     req_S,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_Y,
  output logic [ID_W-1:0]        res_id
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                   res_C
`endif
);

  // First valid requester found scanning circularly from ptr.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  seq_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       s_q, s_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_y_q, res_y_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  rr_next;
  logic [WIDTH-1:0] alu_y;
`ifdef ALU_SEQ_FLAGS_EN
  logic             res_c_q, res_c_d;
  logic             alu_c;
`endif

  assign grant_id = rr_pick(req_valid, rr_ptr_q);
  assign rr_next  = (res_id_q == ID_W'(N_REQ - 1)) ? '0 : res_id_q + 1'b1;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a (a_q),
    .b (b_q),
    .s (s_q),
    .y (alu_y)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .c (alu_c)
`endif
  );

  // Grant is gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == ST_IDLE && |req_valid) req_ready[grant_id] = 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_id_d    = res_id_q;
`ifdef ALU_SEQ_FLAGS_EN
    res_c_d     = res_c_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          a_d     = req_A[int'(grant_id)*WIDTH +: WIDTH];
          b_d     = req_B[int'(grant_id)*WIDTH +: WIDTH];
          s_d     = req_S[int'(grant_id)*2 +: 2];
          id_d    = grant_id;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_y_d     = alu_y;
`ifdef ALU_SEQ_FLAGS_EN
        res_c_d     = alu_c;
`endif
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = rr_next;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= OP_INV;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_id_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      res_c_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_id_q    <= res_id_d;
`ifdef ALU_SEQ_FLAGS_EN
      res_c_q     <= res_c_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_Y     = res_y_q;
  assign res_id    = res_id_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign res_C     = res_c_q;
`endif

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Self-checking bench for alu_req_sequencer: directed cases plus randomized traffic against
// a transaction-level reference model. Checks res_C too when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_req_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int N_REQ = 2;
  localparam int ID_W  = $clog2(N_REQ);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_A, req_B;
  logic [N_REQ*2-1:0]     req_S;
  logic                   res_valid, res_ready;
  logic [WIDTH-1:0]       res_Y;
  logic [ID_W-1:0]        res_id;
`ifdef ALU_SEQ_FLAGS_EN
  logic                   res_C;
`endif

  always #5 clk = ~clk;

  alu_req_sequencer #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .req_S     (req_S),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_Y     (res_Y),
    .res_id    (res_id)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .res_C     (res_C)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stage of the current operation in cycles since acceptance
  // (0 = waiting for a request, 1 = one cycle after accept, 2 = result presented).
  int m_stage, m_ptr, m_id, m_y, m_c, last_grant;
  int obs_grants[$];
  int obs_ids[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int k = 0; k < N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  function automatic void ref_alu(input int a, input int b, input int s,
                                  output int y, output int c);
    int full, r;
    full = 1 << WIDTH;
    case (s)
      0:       begin r = full - 1 - a; c = 0;                 end
      1:       begin r = a + b;        c = int'(r >= full);   end
      2:       begin r = a - b;        c = int'(a < b);       end
      default: begin r = 2 * a;        c = int'(a >= full/2); end
    endcase
    y = (r + full) % full;
  endfunction

  task automatic set_ops(input int id, input int a, input int b, input int s);
    req_A[id*WIDTH +: WIDTH] = WIDTH'(a);
    req_B[id*WIDTH +: WIDTH] = WIDTH'(b);
    req_S[id*2 +: 2]         = 2'(s);
  endtask

  task automatic refresh(input int id);
    set_ops(id, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
  endtask

  // One clock cycle: inputs are already driven; compare, advance the model, wait for next negedge.
  task automatic tick();
    logic [N_REQ-1:0] exp_ready;
    int w;
    #2;
    w = pick(req_valid, m_ptr);
    exp_ready = '0;
    if (m_stage == 0 && w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    if (m_stage == 2) begin
      check("res_valid", res_valid, 1);
      check("res_Y", res_Y, m_y);
      check("res_id", res_id, m_id);
`ifdef ALU_SEQ_FLAGS_EN
      check("res_C", res_C, m_c);
`endif
    end else begin
      check("res_valid_idle", res_valid, 0);
    end
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) obs_grants.push_back(i);
    if (res_valid && res_ready) obs_ids.push_back(int'(res_id));
    last_grant = -1;
    case (m_stage)
      0: if (w >= 0) begin
        ref_alu(int'(req_A[w*WIDTH +: WIDTH]), int'(req_B[w*WIDTH +: WIDTH]),
                int'(req_S[w*2 +: 2]), m_y, m_c);
        m_id       = w;
        last_grant = w;
        m_stage    = 1;
      end
      1: m_stage = 2;
      default: if (res_ready) begin
        m_ptr   = (m_id + 1) % N_REQ;
        m_stage = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic run_single(input int id, input int a, input int b, input int s,
                            input int y, input int c);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    set_ops(id, a, b, s);
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    #1;
    check("dir_valid", res_valid, 1);
    check("dir_y", res_Y, y);
    check("dir_id", res_id, id);
`ifdef ALU_SEQ_FLAGS_EN
    check("dir_c", res_C, c);
`endif
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_Y"}, res_Y, 0);
    check({tag, "_res_id"}, res_id, 0);
`ifdef ALU_SEQ_FLAGS_EN
    check({tag, "_res_C"}, res_C, 0);
`endif
  endtask

  initial begin
    int n1;
    m_stage = 0; m_ptr = 0; m_id = 0; m_y = 0; m_c = 0; last_grant = -1;
    rst_n = 1'b0;
    req_A = '0; req_B = '0; req_S = '0;
    res_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    check_zero_outputs("rst");
    repeat (2) @(negedge clk);
    check_zero_outputs("rst_hold");
    req_valid = '0;
    rst_n     = 1'b1;

    // Directed arithmetic; last op comes from requester 1 so the pointer ends at 0.
    run_single(0, 4, 5, OP_ADD, 9, 0);
    run_single(0, 9, 12, OP_ADD, 5, 1);
    run_single(1, 5, 7, OP_SUB, 14, 1);
    run_single(0, 10, 3, OP_INV, 5, 0);
    run_single(1, 5, 0, OP_DBL, 10, 0);

    // Both requesters always valid, consumer always ready: strict alternation.
    obs_grants.delete();
    obs_ids.delete();
    req_valid = 2'b11;
    refresh(0);
    refresh(1);
    res_ready = 1'b1;
    repeat (12) begin
      tick();
      if (last_grant >= 0) refresh(last_grant);
    end
    req_valid = '0;
    check("rr_n_grants", obs_grants.size(), 4);
    check("rr_n_results", obs_ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant_order", (i < obs_grants.size()) ? obs_grants[i] : -1, i % 2);
      check("rr_id_order", (i < obs_ids.size()) ? obs_ids[i] : -1, i % 2);
    end

    // Backpressure: result held five cycles while both requesters wait.
    req_valid = 2'b01;
    set_ops(0, 11, 6, OP_SUB);
    res_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    refresh(1);
    tick();
    repeat (5) tick();
    res_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();

    // Reset while requester 1's op is one cycle past acceptance.
    run_single(0, 7, 6, OP_ADD, 13, 0);
    req_valid = 2'b11;
    set_ops(0, 2, 2, OP_ADD);
    set_ops(1, 3, 1, OP_SUB);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    m_stage = 0;
    m_ptr   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(0, 6, 9, OP_ADD);
    set_ops(1, 12, 15, OP_SUB);
    repeat (6) tick();
    req_valid = '0;
    tick();

    // Requester 1 valid only while a result is pending: it must never be served.
    obs_grants.delete();
    obs_ids.delete();
    req_valid = 2'b01;
    set_ops(0, 8, 8, OP_DBL);
    res_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    req_valid = 2'b10;
    set_ops(1, 1, 1, OP_ADD);
    tick();
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    repeat (3) tick();
    n1 = 0;
    foreach (obs_ids[i]) if (obs_ids[i] == 1) n1++;
    check("wd_grants", obs_grants.size(), 1);
    check("wd_results", obs_ids.size(), 1);
    check("wd_id1_results", n1, 0);

    // Randomized traffic with withdrawals and random backpressure.
    repeat (800) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && last_grant == i) begin
          if ($urandom_range(0, 1) == 1) refresh(i);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          req_valid[i] = 1'b1;
          refresh(i);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
